// File: rtl/tiny_riscv_pkg.sv
// Shared constants for the tiny RV32I multi-cycle core: opcodes, funct3 codes
// and the control FSM state encoding.
package tiny_riscv_pkg;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [2:0] F3_LS_B  = 3'b000;
    localparam logic [2:0] F3_LS_H  = 3'b001;
    localparam logic [2:0] F3_LS_W  = 3'b010;
    localparam logic [2:0] F3_LS_BU = 3'b100;
    localparam logic [2:0] F3_LS_HU = 3'b101;

    typedef enum logic [2:0] {
        S_FETCH      = 3'd0,
        S_WAIT_INSTR = 3'd1,
        S_EXECUTE    = 3'd2,
        S_LOAD       = 3'd3,
        S_WAIT_DATA  = 3'd4,
        S_STORE      = 3'd5
    } state_t;

endpackage

// File: rtl/tiny_riscv_alu.sv
// Combinational RV32I ALU: arithmetic/logic result selected by funct3 and the
// branch comparison outcome for the same operand pair.
module tiny_riscv_alu
    import tiny_riscv_pkg::*;
(
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic [2:0]  i_funct3,
    input  logic        i_funct7_5,
    input  logic        i_is_imm,
    output logic [31:0] o_result,
    output logic        o_branch_taken
);

    logic [4:0]         w_shamt;
    logic               w_eq;
    logic               w_lt;
    logic               w_ltu;
    logic signed [31:0] w_sra;

    assign w_shamt = i_b[4:0];
    assign w_eq    = (i_a == i_b);
    assign w_lt    = ($signed(i_a) < $signed(i_b));
    assign w_ltu   = (i_a < i_b);
    // Kept as its own signal so the arithmetic shift stays in a signed context.
    assign w_sra   = $signed(i_a) >>> w_shamt;

    always_comb begin
        o_result = 32'd0;
        case (i_funct3)
            F3_ADD:  o_result = (i_funct7_5 && !i_is_imm) ? (i_a - i_b) : (i_a + i_b);
            F3_SLL:  o_result = i_a << w_shamt;
            F3_SLT:  o_result = {31'd0, w_lt};
            F3_SLTU: o_result = {31'd0, w_ltu};
            F3_XOR:  o_result = i_a ^ i_b;
            F3_SR:   o_result = i_funct7_5 ? w_sra : (i_a >> w_shamt);
            F3_OR:   o_result = i_a | i_b;
            F3_AND:  o_result = i_a & i_b;
            default: o_result = 32'd0;
        endcase
    end

    always_comb begin
        o_branch_taken = 1'b0;
        case (i_funct3)
            F3_BEQ:  o_branch_taken = w_eq;
            F3_BNE:  o_branch_taken = !w_eq;
            F3_BLT:  o_branch_taken = w_lt;
            F3_BGE:  o_branch_taken = !w_lt;
            F3_BLTU: o_branch_taken = w_ltu;
            F3_BGEU: o_branch_taken = !w_ltu;
            default: o_branch_taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/tiny_riscv_cpu.sv
// Multi-cycle RV32I core on a single shared memory port with one-cycle read
// latency; register file, immediates, load/store lanes and FSM live here.
module tiny_riscv_cpu
    import tiny_riscv_pkg::*;
#(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
    input  logic        i_Clk,
    input  logic        i_Rst_N,
    output logic [31:0] o_mem_addr,
    input  logic [31:0] i_mem_data,
    output logic        o_read_strobe,
    output logic [31:0] o_mem_write_data,
    output logic [3:0]  o_mem_write_mask
);

    state_t      r_state;
    state_t      w_next_state;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_rs1;
    logic [31:0] r_rs2;
    logic [31:0] r_ls_addr;
    logic [31:0] r_regs [0:31];

    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic [4:0]  w_rd;
    logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_alu_b;
    logic [31:0] w_alu_result;
    logic        w_branch_taken;
    logic        w_exec_we;
    logic [31:0] w_exec_data;
    logic [31:0] w_next_pc;
    logic [31:0] w_ls_addr;
    logic [7:0]  w_ld_byte;
    logic [15:0] w_ld_half;
    logic [31:0] w_load_data;
    logic [31:0] w_st_data;
    logic [3:0]  w_st_mask;
    logic        w_rd_we;
    logic [31:0] w_rd_data;

    assign w_opcode   = r_instr[6:0];
    assign w_funct3   = r_instr[14:12];
    assign w_rd       = r_instr[11:7];
    assign w_imm_i    = {{20{r_instr[31]}}, r_instr[31:20]};
    assign w_imm_s    = {{20{r_instr[31]}}, r_instr[31:25], r_instr[11:7]};
    assign w_imm_b    = {{19{r_instr[31]}}, r_instr[31], r_instr[7], r_instr[30:25], r_instr[11:8], 1'b0};
    assign w_imm_u    = {r_instr[31:12], 12'd0};
    assign w_imm_j    = {{11{r_instr[31]}}, r_instr[31], r_instr[19:12], r_instr[20], r_instr[30:21], 1'b0};
    assign w_pc_plus4 = r_pc + 32'd4;
    assign w_alu_b    = ((w_opcode == OPC_OP) || (w_opcode == OPC_BRANCH)) ? r_rs2 : w_imm_i;
    assign w_ls_addr  = r_rs1 + ((w_opcode == OPC_STORE) ? w_imm_s : w_imm_i);

    tiny_riscv_alu u_alu (
        .i_a            (r_rs1),
        .i_b            (w_alu_b),
        .i_funct3       (w_funct3),
        .i_funct7_5     (r_instr[30]),
        .i_is_imm       (w_opcode == OPC_OP_IMM),
        .o_result       (w_alu_result),
        .o_branch_taken (w_branch_taken)
    );

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_FETCH:      w_next_state = S_WAIT_INSTR;
            S_WAIT_INSTR: w_next_state = S_EXECUTE;
            S_EXECUTE: begin
                if (w_opcode == OPC_LOAD) begin
                    w_next_state = S_LOAD;
                end else if (w_opcode == OPC_STORE) begin
                    w_next_state = S_STORE;
                end else begin
                    w_next_state = S_FETCH;
                end
            end
            S_LOAD:       w_next_state = S_WAIT_DATA;
            S_WAIT_DATA:  w_next_state = S_FETCH;
            S_STORE:      w_next_state = S_FETCH;
            default:      w_next_state = S_FETCH;
        endcase
    end

    // EXECUTE-stage write-back value and PC successor.
    always_comb begin
        w_exec_we   = 1'b0;
        w_exec_data = w_alu_result;
        w_next_pc   = w_pc_plus4;
        case (w_opcode)
            OPC_LUI: begin
                w_exec_we   = 1'b1;
                w_exec_data = w_imm_u;
            end
            OPC_AUIPC: begin
                w_exec_we   = 1'b1;
                w_exec_data = r_pc + w_imm_u;
            end
            OPC_JAL: begin
                w_exec_we   = 1'b1;
                w_exec_data = w_pc_plus4;
                w_next_pc   = r_pc + w_imm_j;
            end
            OPC_JALR: begin
                w_exec_we   = 1'b1;
                w_exec_data = w_pc_plus4;
                w_next_pc   = (r_rs1 + w_imm_i) & 32'hFFFF_FFFE;
            end
            OPC_BRANCH: begin
                if (w_branch_taken) begin
                    w_next_pc = r_pc + w_imm_b;
                end else begin
                    w_next_pc = w_pc_plus4;
                end
            end
            OPC_OP, OPC_OP_IMM: w_exec_we = 1'b1;
            OPC_SYSTEM, OPC_MISC_MEM: w_exec_we = 1'b0;
            default: w_exec_we = 1'b0;
        endcase
    end

    always_comb begin
        w_ld_byte   = i_mem_data[7:0];
        w_load_data = i_mem_data;
        case (r_ls_addr[1:0])
            2'd1:    w_ld_byte = i_mem_data[15:8];
            2'd2:    w_ld_byte = i_mem_data[23:16];
            2'd3:    w_ld_byte = i_mem_data[31:24];
            default: w_ld_byte = i_mem_data[7:0];
        endcase
        w_ld_half = r_ls_addr[1] ? i_mem_data[31:16] : i_mem_data[15:0];
        case (w_funct3)
            F3_LS_B:  w_load_data = {{24{w_ld_byte[7]}}, w_ld_byte};
            F3_LS_H:  w_load_data = {{16{w_ld_half[15]}}, w_ld_half};
            F3_LS_W:  w_load_data = i_mem_data;
            F3_LS_BU: w_load_data = {24'd0, w_ld_byte};
            F3_LS_HU: w_load_data = {16'd0, w_ld_half};
            default:  w_load_data = i_mem_data;
        endcase
    end

    always_comb begin
        w_st_data = r_rs2;
        w_st_mask = 4'b0000;
        case (w_funct3)
            F3_LS_B: begin
                w_st_data = {4{r_rs2[7:0]}};
                w_st_mask = 4'b0001 << r_ls_addr[1:0];
            end
            F3_LS_H: begin
                w_st_data = {2{r_rs2[15:0]}};
                w_st_mask = r_ls_addr[1] ? 4'b1100 : 4'b0011;
            end
            F3_LS_W: w_st_mask = 4'b1111;
            default: w_st_mask = 4'b0000;
        endcase
    end

    always_comb begin
        w_rd_we   = 1'b0;
        w_rd_data = w_exec_data;
        case (r_state)
            S_EXECUTE:   w_rd_we = w_exec_we;
            S_WAIT_DATA: begin
                w_rd_we   = 1'b1;
                w_rd_data = w_load_data;
            end
            default:     w_rd_we = 1'b0;
        endcase
    end

    // Bus controls depend only on state and reset so reset silences them at once.
    always_comb begin
        o_mem_addr       = r_ls_addr;
        o_read_strobe    = 1'b0;
        o_mem_write_mask = 4'b0000;
        if (!i_Rst_N) begin
            o_mem_addr = RESET_ADDR;
        end else begin
            case (r_state)
                S_FETCH: begin
                    o_mem_addr    = r_pc;
                    o_read_strobe = 1'b1;
                end
                S_WAIT_INSTR: o_mem_addr       = r_pc;
                S_LOAD:       o_read_strobe    = 1'b1;
                S_STORE:      o_mem_write_mask = w_st_mask;
                default:      o_read_strobe    = 1'b0;
            endcase
        end
    end

    assign o_mem_write_data = w_st_data;

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_N) begin
            r_state   <= S_FETCH;
            r_pc      <= RESET_ADDR;
            r_instr   <= 32'h0000_0013;
            r_rs1     <= 32'd0;
            r_rs2     <= 32'd0;
            r_ls_addr <= 32'd0;
        end else begin
            r_state <= w_next_state;
            if (r_state == S_WAIT_INSTR) begin
                r_instr <= i_mem_data;
                r_rs1   <= (i_mem_data[19:15] == 5'd0) ? 32'd0 : r_regs[i_mem_data[19:15]];
                r_rs2   <= (i_mem_data[24:20] == 5'd0) ? 32'd0 : r_regs[i_mem_data[24:20]];
            end
            if (r_state == S_EXECUTE) begin
                r_pc      <= w_next_pc;
                r_ls_addr <= w_ls_addr;
            end
        end
    end

    // Register file is deliberately not reset; x0 is never written.
    always_ff @(posedge i_Clk) begin
        if (i_Rst_N && w_rd_we && (w_rd != 5'd0)) begin
            r_regs[w_rd] <= w_rd_data;
        end
    end

endmodule

// File: tb/tb_tiny_riscv_cpu.sv
// Directed bench for tiny_riscv_cpu: small programs in a one-cycle-latency
// memory model, with per-cycle bus logging and hand-computed expectations.
module tb_tiny_riscv_cpu;

    logic        clk;
    logic        rst_n;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        read_strobe;
    logic [31:0] wr_data;
    logic [3:0]  wr_mask;

    logic [31:0] mem [0:1023];
    int          wr_cnt;
    int          wr_base;
    int          n_chk;
    int          n_err;

    logic [5:0]  cyc;
    int          wr_n;
    logic        log_stb  [0:63];
    logic [31:0] log_addr [0:63];
    logic [31:0] log_data [0:63];
    logic [3:0]  log_mask [0:63];

    tiny_riscv_cpu #(.RESET_ADDR(32'h0000_0000)) dut (
        .i_Clk            (clk),
        .i_Rst_N          (rst_n),
        .o_mem_addr       (mem_addr),
        .i_mem_data       (mem_rdata),
        .o_read_strobe    (read_strobe),
        .o_mem_write_data (wr_data),
        .o_mem_write_mask (wr_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory: one-cycle read latency; writes are only counted.
    always_ff @(posedge clk) begin
        if (read_strobe) begin
            mem_rdata <= mem[mem_addr[11:2]];
        end
        if (wr_mask != 4'b0000) begin
            wr_cnt <= wr_cnt + 1;
        end
    end

    // Bus log indexed by cycle number since reset release (first cycle is 1).
    always_ff @(negedge clk) begin
        if (!rst_n) begin
            cyc  <= 6'd0;
            wr_n <= 0;
        end else begin
            if (cyc != 6'd63) begin
                log_stb[cyc + 6'd1]  <= read_strobe;
                log_addr[cyc + 6'd1] <= mem_addr;
                log_data[cyc + 6'd1] <= wr_data;
                log_mask[cyc + 6'd1] <= wr_mask;
                cyc <= cyc + 6'd1;
            end
            if (wr_mask != 4'b0000) begin
                wr_n <= wr_n + 1;
            end
        end
    end

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_cyc(input string tag, input logic [5:0] c, input logic stb, input logic [31:0] addr);
        chk_eq({tag, "_stb"}, {31'd0, log_stb[c]}, {31'd0, stb});
        chk_eq({tag, "_addr"}, log_addr[c], addr);
    endtask

    task automatic chk_reg(input string tag, input logic [4:0] r, input logic [31:0] exp);
        chk_eq(tag, dut.r_regs[r], exp);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0000_0013;
    endtask

    task automatic run(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_eq("rst_strobe", {31'd0, read_strobe}, 32'd0);
        chk_eq("rst_mask", {28'd0, wr_mask}, 32'd0);
        chk_eq("rst_addr", mem_addr, 32'h0000_0000);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic load_store_prog();
        clear_mem();
        mem[0] = 32'h1234_50B7;  // LUI  x1,0x12345
        mem[1] = 32'h6050_8093;  // ADDI x1,x1,0x605
        mem[2] = 32'h0040_0137;  // LUI  x2,0x00400
        mem[3] = 32'h0041_0113;  // ADDI x2,x2,4
        mem[4] = 32'h0011_0123;  // SB   x1,2(x2)
    endtask

    initial begin
        rst_n = 1'b0;
        n_chk = 0;
        n_err = 0;

        // ADDI write-back and 3-cycle timing
        clear_mem();
        mem[0] = 32'h0050_0093;
        reset_dut();
        run(4);
        chk_cyc("addi_fetch0", 6'd1, 1'b1, 32'h0000_0000);
        chk_eq("addi_wait_nostb", {31'd0, log_stb[2]}, 32'd0);
        chk_cyc("addi_fetch4", 6'd4, 1'b1, 32'h0000_0004);
        chk_reg("addi_x1", 5'd1, 32'd5);

        // Byte store to peripheral space, 4-cycle store
        load_store_prog();
        wr_base = wr_cnt;
        reset_dut();
        run(17);
        chk_reg("sb_x1", 5'd1, 32'h1234_5605);
        chk_eq("sb_count", wr_n, 1);
        chk_eq("sb_mask", {28'd0, log_mask[16]}, 32'h0000_0004);
        chk_eq("sb_addr", log_addr[16], 32'h0040_0006);
        chk_eq("sb_data", log_data[16], 32'h0505_0505);
        chk_cyc("sb_next_fetch", 6'd17, 1'b1, 32'h0000_0014);
        chk_eq("sb_mem_writes", wr_cnt - wr_base, 1);

        // Reset asserted while in STORE
        load_store_prog();
        reset_dut();
        run(15);
        wr_base = wr_cnt;
        rst_n = 1'b0;
        #1;
        chk_eq("rst_store_mask", {28'd0, wr_mask}, 32'd0);
        chk_eq("rst_store_strobe", {31'd0, read_strobe}, 32'd0);
        chk_eq("rst_store_addr", mem_addr, 32'h0000_0000);
        run(2);
        chk_eq("rst_store_nowrite", wr_cnt - wr_base, 0);
        clear_mem();
        mem[0] = 32'h0070_0013;  // ADDI x0,x0,7
        mem[1] = 32'h0050_0793;  // ADDI x15,x0,5
        reset_dut();
        run(7);
        chk_cyc("rst_refetch", 6'd1, 1'b1, 32'h0000_0000);
        chk_reg("x0_discard", 5'd15, 32'd5);

        // Byte loads, 5 cycles each
        clear_mem();
        mem[0]    = 32'h1000_0193;  // ADDI x3,x0,0x100
        mem[1]    = 32'h0011_8203;  // LB   x4,1(x3)
        mem[2]    = 32'h0011_C283;  // LBU  x5,1(x3)
        mem[10'h40] = 32'h0000_80FF;
        reset_dut();
        run(14);
        chk_cyc("lb_addr", 6'd7, 1'b1, 32'h0000_0101);
        chk_cyc("lbu_fetch", 6'd9, 1'b1, 32'h0000_0008);
        chk_cyc("lbu_addr", 6'd12, 1'b1, 32'h0000_0101);
        chk_eq("lbu_wait_nostb", {31'd0, log_stb[13]}, 32'd0);
        chk_cyc("ld_next_fetch", 6'd14, 1'b1, 32'h0000_000C);
        chk_reg("lb_x4", 5'd4, 32'hFFFF_FF80);
        chk_reg("lbu_x5", 5'd5, 32'h0000_0080);

        // Taken BEQ backwards, then not-taken BNE
        clear_mem();
        mem[0] = 32'h0200_006F;  // JAL x0,+0x20
        mem[8] = 32'hFE00_0CE3;  // BEQ x0,x0,-8
        reset_dut();
        run(7);
        chk_cyc("jal_target", 6'd4, 1'b1, 32'h0000_0020);
        chk_cyc("beq_taken", 6'd7, 1'b1, 32'h0000_0018);
        mem[8] = 32'h0000_1463;  // BNE x0,x0,+8
        reset_dut();
        run(7);
        chk_cyc("bne_not_taken", 6'd7, 1'b1, 32'h0000_0024);

        // JALR with odd target, then shifts and compares
        clear_mem();
        mem[0]  = 32'h1030_0313;  // ADDI x6,x0,0x103
        mem[1]  = 32'h03C0_006F;  // JAL  x0,+0x3C
        mem[16] = 32'h0003_00E7;  // JALR x1,0(x6)
        mem[64] = 32'h8000_03B7;  // LUI  x7,0x80000
        mem[65] = 32'h41F3_D413;  // SRAI x8,x7,31
        mem[66] = 32'h01F0_0493;  // ADDI x9,x0,31
        mem[67] = 32'h4093_D533;  // SRA  x10,x7,x9
        mem[68] = 32'h4090_05B3;  // SUB  x11,x0,x9
        mem[69] = 32'h0093_A633;  // SLT  x12,x7,x9
        mem[70] = 32'h0093_B6B3;  // SLTU x13,x7,x9
        reset_dut();
        run(10);
        chk_cyc("jalr_fetch", 6'd7, 1'b1, 32'h0000_0040);
        chk_cyc("jalr_target", 6'd10, 1'b1, 32'h0000_0102);
        chk_reg("jalr_link", 5'd1, 32'h0000_0044);
        run(21);
        chk_reg("srai_x8", 5'd8, 32'hFFFF_FFFF);
        chk_reg("sra_x10", 5'd10, 32'hFFFF_FFFF);
        chk_reg("sub_x11", 5'd11, 32'hFFFF_FFE1);
        chk_reg("slt_x12", 5'd12, 32'd1);
        chk_reg("sltu_x13", 5'd13, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
